// File: rtl/matrix_scan_ctrl_if.sv
// Word handshake between the LED matrix scan controller and the serial shifter.
// Latency: none (plain wires); sh_data[15:8] row select, sh_data[7:0] column data.
// Backpressure: master holds sh_valid/sh_data stable until slave raises sh_ready.
// Modports: master = scan controller (drives sh_valid, sh_data), slave = shifter (drives sh_ready).
interface matrix_scan_ctrl_if;
    logic        sh_valid;
    logic        sh_ready;
    logic [15:0] sh_data;

    modport master (output sh_valid, output sh_data, input sh_ready);
    modport slave  (input sh_valid, input sh_data, output sh_ready);
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Double-buffered 8x8 LED matrix row scanner feeding a serial shifter one 16-bit word per row.
// Latency: LOAD 1 clk + SEND >=1 clk + DWELL DWELL_CYCLES clks per row (34 clks/row at 32).
// Backpressure: SEND/BLANK stall with sh_valid and sh_data held until sh_ready; dwell never starts early.
// Ports: clk_100mhz, resn (async active-low), enable, wr_en/wr_row/wr_data (back buffer write),
//        swap_req/swap_ack, sh (word handshake, master side), row_idx, frame_start, out_en.
// Optional macro MATRIX_PWM_EN adds a 4-bit brightness input and 16-slot PWM of out_en per dwell.
module matrix_scan_ctrl #(
    parameter int DWELL_CYCLES   = 12500,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic               clk_100mhz,
    input  logic               resn,
    input  logic               enable,
    input  logic               wr_en,
    input  logic [2:0]         wr_row,
    input  logic [7:0]         wr_data,
    input  logic               swap_req,
    output logic               swap_ack,
`ifdef MATRIX_PWM_EN
    input  logic [3:0]         brightness,
`endif
    matrix_scan_ctrl_if.master sh,
    output logic [2:0]         row_idx,
    output logic               frame_start,
    output logic               out_en
);

    localparam int CW = $clog2(DWELL_CYCLES);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, DWELL, BLANK} state_t;

    state_t          state, state_nxt;
    logic            sh_valid_q;
    logic [15:0]     sh_data_q;
    logic [CW-1:0]   dwell_cnt;
    logic [7:0][7:0] front, back, back_wr;
    logic            pending;
    logic            accept, dwell_done, swap_now;
    logic [7:0]      row_sel, col_bits;

    assign sh.sh_valid = sh_valid_q;
    assign sh.sh_data  = sh_data_q;

    assign accept     = sh_valid_q && sh.sh_ready;
    assign dwell_done = (state == DWELL) && (dwell_cnt == '0);
    // The swap rides on the row 7 -> 0 wrap so a frame is never shown half old, half new.
    assign swap_now   = dwell_done && (row_idx == 3'd7) && pending;

    assign row_sel  = 8'b1 << row_idx;
    assign col_bits = front[row_idx] ^ {8{COL_ACTIVE_LOW != 0}};

`ifdef MATRIX_PWM_EN
    localparam int SLOT_CYCLES = DWELL_CYCLES / 16;
    localparam int SW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [SW-1:0] slot_cnt;
    logic [3:0]    slot_idx;
    logic [3:0]    bright_q;
    logic          pwm_on;

    // Brightness is captured at dwell entry so a mid-row change cannot distort that row.
    always_ff @(posedge clk_100mhz or negedge resn) begin
        if (!resn) begin
            slot_cnt <= '0;
            slot_idx <= '0;
            bright_q <= '0;
        end else if (state == SEND && accept) begin
            slot_cnt <= SW'(SLOT_CYCLES - 1);
            slot_idx <= '0;
            bright_q <= brightness;
        end else if (state == DWELL) begin
            if (slot_cnt == '0) begin
                slot_cnt <= SW'(SLOT_CYCLES - 1);
                slot_idx <= slot_idx + 4'd1;
            end else begin
                slot_cnt <= slot_cnt - SW'(1);
            end
        end
    end

    assign pwm_on = (state == DWELL) && (slot_idx <= bright_q);
`endif

    always_ff @(posedge clk_100mhz or negedge resn) begin
        if (!resn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        out_en      = 1'b0;
        frame_start = 1'b0;
        swap_ack    = swap_now;
        case (state)
            IDLE:    if (enable) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (accept) state_nxt = DWELL;
            DWELL:   if (dwell_cnt == '0) state_nxt = enable ? LOAD : BLANK;
            BLANK:   if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state == SEND && accept && row_idx == 3'd0) frame_start = 1'b1;
`ifdef MATRIX_PWM_EN
        out_en = pwm_on;
`else
        out_en = (state == LOAD) || (state == SEND) || (state == DWELL);
`endif
    end

    // Word register, row pointer and dwell counter.
    always_ff @(posedge clk_100mhz or negedge resn) begin
        if (!resn) begin
            sh_valid_q <= 1'b0;
            sh_data_q  <= '0;
            row_idx    <= '0;
            dwell_cnt  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    sh_valid_q <= 1'b1;
                    sh_data_q  <= {row_sel, col_bits};
                end
                SEND: begin
                    if (accept) begin
                        sh_valid_q <= 1'b0;
                        dwell_cnt  <= CW'(DWELL_CYCLES - 1);
                    end
                end
                DWELL: begin
                    if (dwell_cnt == '0) begin
                        row_idx <= row_idx + 3'd1;
                        // Blank word goes out raw: all-zero row select turns the matrix off
                        // regardless of column polarity.
                        if (!enable) begin
                            sh_valid_q <= 1'b1;
                            sh_data_q  <= '0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - CW'(1);
                    end
                end
                BLANK: begin
                    if (accept) begin
                        sh_valid_q <= 1'b0;
                        row_idx    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A write coinciding with the swap lands in the outgoing back buffer, so it is
    // visible in the very frame that buffer starts being displayed.
    always_comb begin
        back_wr = back;
        if (wr_en) back_wr[wr_row] = wr_data;
    end

    always_ff @(posedge clk_100mhz or negedge resn) begin
        if (!resn) begin
            front   <= '0;
            back    <= '0;
            pending <= 1'b0;
        end else if (swap_now) begin
            front   <= back_wr;
            back    <= front;
            // A request arriving in the swap cycle itself is kept for the next frame.
            pending <= swap_req;
        end else begin
            back <= back_wr;
            if (swap_req) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl (DWELL_CYCLES=32, active-low columns).
// Latency: words expected 34 clks apart, blank word 33 clks after the last row word.
// Backpressure: sh_ready is held low at scan start and during the mid-handshake reset.
module tb_matrix_scan_ctrl;

    localparam int DWELL = 32;

    logic       clk_100mhz = 1'b0;
    logic       resn;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic [2:0] row_idx;
    logic       frame_start;
    logic       out_en;

    matrix_scan_ctrl_if sh_if ();

    matrix_scan_ctrl #(.DWELL_CYCLES(DWELL), .COL_ACTIVE_LOW(1)) dut (
        .clk_100mhz  (clk_100mhz),
        .resn        (resn),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .sh          (sh_if),
        .row_idx     (row_idx),
        .frame_start (frame_start),
        .out_en      (out_en)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        logic [2:0]  row;
        logic [7:0]  wdata;
        logic [15:0] word;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic        fs;
        int          gap;
    } exp_t;

    vec_t vec [24];
    exp_t sb [$];
    exp_t mon_e;
    exp_t e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_acc = 0;
    int acc_cnt  = 0;
    int swap_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (acc_cnt < n && t < 3000) begin
            tick();
            t++;
        end
        if (acc_cnt < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout_words: got %0d expected %0d", acc_cnt, n);
        end
    endtask

    task automatic wait_swap();
        int t = 0;
        while (!swap_ack && t < 3000) begin
            tick();
            t++;
        end
        if (!swap_ack) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout_swap_ack: got 0 expected 1");
        end
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!sh_if.sh_valid && t < 100) begin
            tick();
            t++;
        end
        if (!sh_if.sh_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout_valid: got 0 expected 1");
        end
    endtask

    // Scoreboard side: every accepted word is popped and compared.
    always @(negedge clk_100mhz) begin
        cyc++;
        if (swap_ack) begin
            swap_cnt++;
            chk("swap_ack_on_row7", 32'(row_idx), 32'd7);
        end
        if (sh_if.sh_valid && sh_if.sh_ready) begin
            acc_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got %0h expected none", sh_if.sh_data);
            end else begin
                mon_e = sb.pop_front();
                chk("word", 32'(sh_if.sh_data), 32'(mon_e.word));
                chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
                chk("out_en_at_accept", 32'(out_en), 32'(mon_e.word != 16'h0000));
                if (mon_e.gap != 0) chk("word_spacing", 32'(cyc - last_acc), 32'(mon_e.gap));
            end
            last_acc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [7:0] oh;

        resn     = 1'b0;
        enable   = 1'b0;
        wr_en    = 1'b0;
        wr_row   = 3'd0;
        wr_data  = 8'h00;
        swap_req = 1'b0;
        sh_if.sh_ready = 1'b0;

        // Three frame patterns: A = walking one, B = 11..88, C = walking one from the top.
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 8; r++) begin
                case (p)
                    0:       w = 8'h01 << r;
                    1:       w = 8'(8'h11 * (r + 1));
                    default: w = 8'h80 >> r;
                endcase
                oh = 8'h01 << r;
                vec[p*8+r].row   = 3'(r);
                vec[p*8+r].wdata = w;
                vec[p*8+r].word  = {oh, ~w};
            end
        end

        // Reset values.
        repeat (3) tick();
        chk("rst_sh_valid",    32'(sh_if.sh_valid), 32'd0);
        chk("rst_sh_data",     32'(sh_if.sh_data),  32'd0);
        chk("rst_row_idx",     32'(row_idx),        32'd0);
        chk("rst_frame_start", 32'(frame_start),    32'd0);
        chk("rst_swap_ack",    32'(swap_ack),       32'd0);
        chk("rst_out_en",      32'(out_en),         32'd0);

        resn = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_row  = vec[i].row;
            wr_data = vec[i].wdata;
            tick();
        end
        wr_en    = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        chk("idle_out_en",   32'(out_en),         32'd0);
        chk("idle_sh_valid", 32'(sh_if.sh_valid), 32'd0);

        // Expected words: frame 0 blank front, 1 = A with row 7 overwritten at the swap,
        // 2 = B, 3 and 4 = C (4 stops after row 5), then the blank word.
        for (int f = 0; f < 5; f++) begin
            for (int r = 0; r < 8; r++) begin
                if (f == 4 && r > 5) continue;
                oh = 8'h01 << r;
                if (f == 0)                e.word = {oh, 8'hFF};
                else if (f == 1 && r == 7) e.word = {oh, ~8'h3C};
                else if (f == 1)           e.word = vec[r].word;
                else if (f == 2)           e.word = vec[8+r].word;
                else                       e.word = vec[16+r].word;
                e.fs  = (r == 0);
                e.gap = (f == 0 && r == 0) ? 0 : 34;
                sb.push_back(e);
            end
        end
        e.word = 16'h0000;
        e.fs   = 1'b0;
        e.gap  = 33;
        sb.push_back(e);

        // Backpressure on the very first word.
        enable = 1'b1;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(sh_if.sh_valid), 32'd1);
            chk("stall_data",  32'(sh_if.sh_data),  32'h01FF);
            tick();
        end
        chk("stall_no_accept", 32'(acc_cnt), 32'd0);
        sh_if.sh_ready = 1'b1;
        tick();
        chk("accept_first_ready", 32'(acc_cnt),        32'd1);
        chk("valid_drops",        32'(sh_if.sh_valid), 32'd0);
        chk("dwell_out_en",       32'(out_en),         32'd1);

        // First swap: write row 7 and re-request in the swap cycle itself.
        wait_swap();
        wr_en    = 1'b1;
        wr_row   = 3'd7;
        wr_data  = 8'h3C;
        swap_req = 1'b1;
        tick();
        wr_en    = 1'b0;
        swap_req = 1'b0;
        chk("wrap_row_idx", 32'(row_idx), 32'd0);
        for (int i = 8; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_row  = vec[i].row;
            wr_data = vec[i].wdata;
            tick();
        end
        wr_en = 1'b0;

        // Second swap comes from the request held over from the first swap cycle.
        wait_swap();
        tick();
        for (int i = 16; i < 24; i++) begin
            wr_en   = 1'b1;
            wr_row  = vec[i].row;
            wr_data = vec[i].wdata;
            tick();
        end
        wr_en = 1'b0;

        // Three requests during row 3 must produce one swap only.
        wait_words(20);
        for (int i = 0; i < 3; i++) begin
            swap_req = 1'b1;
            tick();
            swap_req = 1'b0;
            tick();
        end
        chk("swaps_before_third", 32'(swap_cnt), 32'd2);
        wait_swap();
        tick();
        chk("swaps_after_third", 32'(swap_cnt), 32'd3);

        // Disable during row 5 of frame 4.
        wait_words(38);
        repeat (5) tick();
        enable = 1'b0;
        wait_words(39);
        repeat (2) tick();
        chk("off_row_idx",  32'(row_idx),        32'd0);
        chk("off_out_en",   32'(out_en),         32'd0);
        chk("off_sh_valid", 32'(sh_if.sh_valid), 32'd0);
        repeat (80) tick();
        chk("total_swaps", 32'(swap_cnt), 32'd3);
        chk("total_words", 32'(acc_cnt),  32'd39);

        // Reset while a word is being offered.
        sh_if.sh_ready = 1'b0;
        enable = 1'b1;
        wait_valid();
        @(negedge clk_100mhz);
        #2;
        resn = 1'b0;
        #1;
        chk("async_valid_drop", 32'(sh_if.sh_valid), 32'd0);
        chk("async_data_clear", 32'(sh_if.sh_data),  32'd0);
        enable = 1'b0;
        repeat (3) tick();
        chk("rst2_row_idx", 32'(row_idx), 32'd0);
        e.word = 16'h01FF;
        e.fs   = 1'b1;
        e.gap  = 0;
        sb.push_back(e);
        e.word = 16'h0000;
        e.fs   = 1'b0;
        e.gap  = 33;
        sb.push_back(e);
        resn = 1'b1;
        sh_if.sh_ready = 1'b1;
        enable = 1'b1;
        wait_words(40);
        enable = 1'b0;
        wait_words(41);
        repeat (5) tick();
        chk("end_out_en",  32'(out_en),   32'd0);
        chk("end_row_idx", 32'(row_idx),  32'd0);
        chk("sb_drained",  32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
